// File: rtl/write_resp_router_1_2_pkg.sv
// write_resp_router_1_2_pkg: shared types and constants for the write-response router
//   bresp_e          : AXI B-channel response encodings
//   FIFO_DEPTH_DEF   : default number of outstanding write transactions
//   MST_S00/MST_S01  : master ids stored in the ordering FIFO
package write_resp_router_1_2_pkg;
    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam logic MST_S00 = 1'b0;
    localparam logic MST_S01 = 1'b1;
endpackage

// File: rtl/write_resp_router_1_2_fifo.sv
// txn_order_fifo: in-order FIFO of 1-bit master ids for outstanding write transactions
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : enqueue din (ignored while full)
//   pop        : dequeue head (ignored while empty)
//   dout       : head entry
//   full, empty, count : occupancy status
module txn_order_fifo
    import write_resp_router_1_2_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           din,
    input  logic           pop,
    output logic           dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);
    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = count == (PTR_W+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/write_resp_router_1_2.sv
// write_resp_router_1_2: routes slave B responses back to the owning master (S00/S01), in AW order
//   ACLK, ARESETN                  : clock, asynchronous active-low reset
//   Selected_Slave, M_AXI_awvalid/awready : AW handshake and owning master
//   aw_block                       : FIFO full, parent must gate AW
//   M_AXI_bresp/bvalid/bready      : slave B channel
//   S0x_AXI_bresp/bvalid/bready    : master B channels
//   outstanding                    : FIFO occupancy
//   orphan_err                     : sticky, bvalid seen with nothing outstanding
module write_resp_router_1_2
    import write_resp_router_1_2_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic           ACLK,
    input  logic           ARESETN,
    input  logic           Selected_Slave,
    input  logic           M_AXI_awvalid,
    input  logic           M_AXI_awready,
    output logic           aw_block,
    input  logic [1:0]     M_AXI_bresp,
    input  logic           M_AXI_bvalid,
    output logic           M_AXI_bready,
    output logic [1:0]     S00_AXI_bresp,
    output logic           S00_AXI_bvalid,
    input  logic           S00_AXI_bready,
    output logic [1:0]     S01_AXI_bresp,
    output logic           S01_AXI_bvalid,
    input  logic           S01_AXI_bready,
    output logic [PTR_W:0] outstanding,
    output logic           orphan_err
);
    logic head, full, empty, sel0, sel1, aw_hs, b_hs;

    assign aw_hs = M_AXI_awvalid & M_AXI_awready & ~full;
    assign b_hs  = M_AXI_bvalid & M_AXI_bready;

    txn_order_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (aw_hs),
        .din   (Selected_Slave),
        .pop   (b_hs),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    // Routing depends only on registered head/empty, so aw_block has no path from B inputs.
    always_comb begin
        sel0           = ~empty & (head == MST_S00);
        sel1           = ~empty & (head == MST_S01);
        aw_block       = full;
        S00_AXI_bvalid = M_AXI_bvalid & sel0;
        S01_AXI_bvalid = M_AXI_bvalid & sel1;
        S00_AXI_bresp  = sel0 ? M_AXI_bresp : BRESP_OKAY;
        S01_AXI_bresp  = sel1 ? M_AXI_bresp : BRESP_OKAY;
        M_AXI_bready   = (sel0 & S00_AXI_bready) | (sel1 & S01_AXI_bready);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            orphan_err <= 1'b0;
        else if (M_AXI_bvalid & empty)
            orphan_err <= 1'b1;
    end
endmodule

// File: tb/tb_write_resp_router_1_2.sv
// tb_write_resp_router_1_2: directed stimulus with a queue-based reference model and per-cycle compare
module tb_write_resp_router_1_2;
    import write_resp_router_1_2_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic       Selected_Slave = 1'b0;
    logic       M_AXI_awvalid = 1'b0;
    logic       M_AXI_awready = 1'b0;
    logic       aw_block;
    logic [1:0] M_AXI_bresp = 2'b00;
    logic       M_AXI_bvalid = 1'b0;
    logic       M_AXI_bready;
    logic [1:0] S00_AXI_bresp;
    logic       S00_AXI_bvalid;
    logic       S00_AXI_bready = 1'b0;
    logic [1:0] S01_AXI_bresp;
    logic       S01_AXI_bvalid;
    logic       S01_AXI_bready = 1'b0;
    logic [2:0] outstanding;
    logic       orphan_err;

    int checks = 0;
    int errors = 0;

    write_resp_router_1_2 dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .Selected_Slave(Selected_Slave),
        .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready), .aw_block(aw_block),
        .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
        .S00_AXI_bresp(S00_AXI_bresp), .S00_AXI_bvalid(S00_AXI_bvalid), .S00_AXI_bready(S00_AXI_bready),
        .S01_AXI_bresp(S01_AXI_bresp), .S01_AXI_bvalid(S01_AXI_bvalid), .S01_AXI_bready(S01_AXI_bready),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of owning-master ids in AW order.
    bit q[$];
    bit m_orphan = 0;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            q.delete();
            m_orphan = 0;
        end else begin
            bit pop_ok, push_ok;
            pop_ok  = M_AXI_bvalid && q.size() > 0 &&
                      (q[0] ? S01_AXI_bready : S00_AXI_bready);
            push_ok = M_AXI_awvalid && M_AXI_awready && q.size() < 4;
            if (M_AXI_awvalid && M_AXI_awready && q.size() == 4)
                chk("aw_handshake_while_full", 1, 0);
            if (M_AXI_bvalid && q.size() == 0)
                m_orphan = 1;
            if (pop_ok)
                void'(q.pop_front());
            if (push_ok)
                q.push_back(Selected_Slave);
        end
    end

    always @(negedge ACLK) begin
        bit has, to1;
        has = q.size() > 0;
        to1 = has && q[0];
        chk("cmp_outstanding", int'(outstanding), q.size());
        chk("cmp_aw_block", int'(aw_block), int'(q.size() == 4));
        chk("cmp_orphan", int'(orphan_err), int'(m_orphan));
        chk("cmp_s00_bvalid", int'(S00_AXI_bvalid), int'(M_AXI_bvalid && has && !to1));
        chk("cmp_s01_bvalid", int'(S01_AXI_bvalid), int'(M_AXI_bvalid && to1));
        chk("cmp_s00_bresp", int'(S00_AXI_bresp), (has && !to1) ? int'(M_AXI_bresp) : 0);
        chk("cmp_s01_bresp", int'(S01_AXI_bresp), to1 ? int'(M_AXI_bresp) : 0);
        chk("cmp_m_bready", int'(M_AXI_bready),
            int'(has && (to1 ? S01_AXI_bready : S00_AXI_bready)));
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw(input logic id);
        Selected_Slave = id;
        M_AXI_awvalid  = 1'b1;
        M_AXI_awready  = 1'b1;
        step();
        M_AXI_awvalid  = 1'b0;
        M_AXI_awready  = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("reset_outstanding", int'(outstanding), 0);
        chk("reset_aw_block", int'(aw_block), 0);
        chk("reset_orphan", int'(orphan_err), 0);
        ARESETN = 1'b1;
        step();

        // Single write from S00
        aw(MST_S00);
        chk("single_outstanding_1", int'(outstanding), 1);
        step();
        step();
        M_AXI_bvalid = 1'b1; M_AXI_bresp = BRESP_OKAY; S00_AXI_bready = 1'b1;
        #1;
        chk("single_s00_bvalid", int'(S00_AXI_bvalid), 1);
        chk("single_s01_bvalid", int'(S01_AXI_bvalid), 0);
        chk("single_m_bready", int'(M_AXI_bready), 1);
        step();
        M_AXI_bvalid = 1'b0;
        chk("single_outstanding_0", int'(outstanding), 0);

        // Interleaved order
        aw(MST_S01);
        aw(MST_S00);
        aw(MST_S01);
        chk("inter_outstanding_3", int'(outstanding), 3);
        S00_AXI_bready = 1'b1; S01_AXI_bready = 1'b1;
        M_AXI_bvalid = 1'b1; M_AXI_bresp = BRESP_SLVERR;
        #1;
        chk("inter1_s01_bvalid", int'(S01_AXI_bvalid), 1);
        chk("inter1_s01_bresp", int'(S01_AXI_bresp), 2);
        chk("inter1_s00_bvalid", int'(S00_AXI_bvalid), 0);
        step();
        M_AXI_bresp = BRESP_OKAY;
        #1;
        chk("inter2_s00_bvalid", int'(S00_AXI_bvalid), 1);
        chk("inter2_s00_bresp", int'(S00_AXI_bresp), 0);
        chk("inter2_s01_bvalid", int'(S01_AXI_bvalid), 0);
        step();
        M_AXI_bresp = BRESP_DECERR;
        #1;
        chk("inter3_s01_bvalid", int'(S01_AXI_bvalid), 1);
        chk("inter3_s01_bresp", int'(S01_AXI_bresp), 3);
        step();
        M_AXI_bvalid = 1'b0;
        chk("inter_outstanding_0", int'(outstanding), 0);

        // Back-pressure from S00; S01 ready must not matter
        aw(MST_S00);
        M_AXI_bvalid = 1'b1; M_AXI_bresp = BRESP_EXOKAY;
        S00_AXI_bready = 1'b0; S01_AXI_bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_m_bready", int'(M_AXI_bready), 0);
            chk("bp_s00_bvalid", int'(S00_AXI_bvalid), 1);
            chk("bp_s00_bresp", int'(S00_AXI_bresp), 1);
            step();
        end
        chk("bp_outstanding_held", int'(outstanding), 1);
        S00_AXI_bready = 1'b1;
        #1;
        chk("bp_release_m_bready", int'(M_AXI_bready), 1);
        step();
        M_AXI_bvalid = 1'b0;
        chk("bp_outstanding_0", int'(outstanding), 0);

        // Full
        aw(MST_S00);
        aw(MST_S01);
        aw(MST_S00);
        aw(MST_S01);
        chk("full_aw_block", int'(aw_block), 1);
        chk("full_outstanding", int'(outstanding), 4);
        M_AXI_bvalid = 1'b1;
        #1;
        chk("full_pop_aw_block_same", int'(aw_block), 1);
        step();
        M_AXI_bvalid = 1'b0;
        #1;
        chk("full_pop_aw_block_next", int'(aw_block), 0);
        chk("full_pop_outstanding", int'(outstanding), 3);
        M_AXI_bvalid = 1'b1;
        aw(MST_S00);
        M_AXI_bvalid = 1'b0;
        chk("pushpop_outstanding", int'(outstanding), 3);
        M_AXI_bvalid = 1'b1;
        step();
        step();
        step();
        M_AXI_bvalid = 1'b0;
        chk("drain_outstanding", int'(outstanding), 0);

        // Orphan
        M_AXI_bvalid = 1'b1; M_AXI_bresp = BRESP_SLVERR;
        #1;
        chk("orphan_m_bready", int'(M_AXI_bready), 0);
        chk("orphan_s00_bvalid", int'(S00_AXI_bvalid), 0);
        chk("orphan_s01_bvalid", int'(S01_AXI_bvalid), 0);
        step();
        M_AXI_bvalid = 1'b0;
        chk("orphan_set", int'(orphan_err), 1);
        step();
        step();
        chk("orphan_sticky", int'(orphan_err), 1);
        ARESETN = 1'b0;
        #1;
        chk("orphan_cleared", int'(orphan_err), 0);
        step();
        ARESETN = 1'b1;
        step();

        // Reset mid-flight
        aw(MST_S00);
        aw(MST_S01);
        chk("mid_outstanding_2", int'(outstanding), 2);
        S00_AXI_bready = 1'b0; S01_AXI_bready = 1'b0;
        M_AXI_bvalid = 1'b1;
        #1;
        chk("mid_s00_bvalid_pre", int'(S00_AXI_bvalid), 1);
        ARESETN = 1'b0;
        #1;
        chk("mid_outstanding_rst", int'(outstanding), 0);
        chk("mid_s00_bvalid_rst", int'(S00_AXI_bvalid), 0);
        chk("mid_m_bready_rst", int'(M_AXI_bready), 0);
        M_AXI_bvalid = 1'b0;
        step();
        ARESETN = 1'b1;
        step();
        aw(MST_S01);
        M_AXI_bvalid = 1'b1; M_AXI_bresp = BRESP_SLVERR; S01_AXI_bready = 1'b1;
        #1;
        chk("post_s01_bvalid", int'(S01_AXI_bvalid), 1);
        chk("post_s01_bresp", int'(S01_AXI_bresp), 2);
        chk("post_s00_bvalid", int'(S00_AXI_bvalid), 0);
        step();
        M_AXI_bvalid = 1'b0;
        chk("post_outstanding_0", int'(outstanding), 0);
        chk("post_orphan", int'(orphan_err), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
